// File: rtl/pipe_stage_skid.sv
// ----------------------------------------------------------------------------
// pipe_stage_skid
// Back-pressure-aware pipeline stage register with a 2-entry skid buffer.
// The main (head) register drives the outputs. The skid register catches the
// one entry that can arrive while downstream stalls. This lets in_ready be a
// registered signal and still sustain one entry per cycle.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, drops all entries
//   flush      : synchronous flush, kills all held entries (data regs hold)
//   in_valid   : upstream entry present
//   in_ready   : stage can accept (registered, never depends on out_ready)
//   in_data    : upstream data bundle  [DATA_W]
//   in_ctrl    : upstream control bundle [CTRL_W]
//   out_valid  : stage holds an entry for downstream
//   out_ready  : downstream accepts
//   out_data   : data bundle of head entry
//   out_ctrl   : control bundle of head entry, zero when out_valid=0
//   occupancy  : entries held (0, 1 or 2)
//
// Optional build macro PIPE_STAGE_STATS_EN adds:
//   stall_cnt  : cycles with out_valid & !out_ready (saturating, 32 bit)
//   flush_cnt  : flush cycles that hit a non-empty stage (saturating, 32 bit)
// ----------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 96,
    parameter int unsigned CTRL_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    localparam int unsigned OCC_W = 2;
    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [OCC_W-1:0]  occ_q, occ_d;

    logic acc_in_c;
    logic acc_out_c;

    // Handshakes use only registered flags, so out_ready never reaches in_ready.
    assign acc_in_c  = in_valid & in_ready_q;
    assign acc_out_c = out_valid_q & out_ready;

    // Next-state and storage update.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (flush) begin
            // Bubble: kill control, keep data; any capture this cycle is dropped.
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (acc_in_c) begin
                        state_d     = ST_ONE;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                ST_ONE: begin
                    if (acc_in_c && acc_out_c) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (acc_in_c) begin
                        // Downstream stalled: park the new entry behind the head.
                        state_d     = ST_TWO;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (acc_out_c) begin
                        state_d     = ST_EMPTY;
                        main_ctrl_d = '0;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a drain can happen.
                    if (acc_out_c) begin
                        state_d     = ST_ONE;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        skid_ctrl_d = '0;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_ctrl_d = '0;
                    skid_ctrl_d = '0;
                end
            endcase
        end

        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
        unique case (state_d)
            ST_ONE:  occ_d = OCC_W'(1);
            ST_TWO:  occ_d = OCC_W'(2);
            default: occ_d = OCC_W'(0);
        endcase
    end

    // State and storage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            occ_q       <= occ_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    // main ctrl is cleared whenever the stage empties, so it reads zero when idle.
    assign out_ctrl  = main_ctrl_q;
    assign occupancy = occ_q;

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters; flush does not clear them.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (state_q != ST_EMPTY) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
